// File: rtl/sipo_lsb_rx_pkg.sv
// Shared types for the LSB-first serial-to-parallel receiver.
package sipo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage : sipo_pkg

// File: rtl/sipo_lsb_rx_if.sv
// Serial input, word output handshake and status flags of sipo_lsb_rx.
interface sipo_lsb_rx_if #(
  parameter int DW = 4
) ();

  logic          enb;
  logic          sin;
  logic          sin_vld;
  logic          sof;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy;
  logic          busy;
  logic          ovf;
  logic          ovf_clr;
  logic          frm_err;

  // Environment side: drives the serial stream and consumes words.
  modport master (
    output enb, sin, sin_vld, sof, dout_rdy, ovf_clr,
    input  dout, dout_vld, busy, ovf, frm_err
  );

  // Receiver side.
  modport slave (
    input  enb, sin, sin_vld, sof, dout_rdy, ovf_clr,
    output dout, dout_vld, busy, ovf, frm_err
  );

endinterface : sipo_lsb_rx_if

// File: rtl/sipo_lsb_rx_bit_cnt.sv
// Bit position counter: load-to-1 on start of word, count up, wrap after DW bits.
module bit_cnt #(
  parameter int DW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load1,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(DW);

  logic [CW-1:0] cnt_r;

  // Counter register; load1 has priority so a restarted word always begins at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (load1) begin
      cnt_r <= CW'(1);
    end else if (inc) begin
      if (last) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign last = (cnt_r == CW'(DW - 1));

endmodule : bit_cnt

// File: rtl/sipo_lsb_rx.sv
// Reassembles framed LSB-first serial words into a single-entry valid/ready buffer,
// flagging overflow and framing errors instead of back-pressuring the serial side.
module sipo_lsb_rx
  import sipo_pkg::*;
#(
  parameter int DW = 4
) (
  input logic         clk,
  input logic         rst,
  sipo_lsb_rx_if.slave bus
);

  rx_state_e     state_r;
  logic [DW-1:0] sr_r;
  logic [DW-1:0] dout_r;
  logic          dout_vld_r;
  logic          busy_r;
  logic          ovf_r;
  logic          frm_err_r;

  logic          strobe_s;
  logic          load1_s;
  logic          inc_s;
  logic          last_s;
  logic          done_s;
  logic          hs_s;
  logic [DW-1:0] word_s;

  assign strobe_s = bus.enb & bus.sin_vld;
  assign load1_s  = strobe_s & bus.sof;
  assign inc_s    = strobe_s & ~bus.sof & (state_r == SHIFT);
  assign done_s   = inc_s & last_s;
  assign hs_s     = dout_vld_r & bus.dout_rdy;
  assign word_s   = {bus.sin, sr_r[DW-1:1]};

  bit_cnt #(
    .DW (DW)
  ) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .load1 (load1_s),
    .inc   (inc_s),
    .last  (last_s)
  );

  // Framing FSM with registered busy and frame-error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      frm_err_r <= 1'b0;
    end else begin
      frm_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load1_s) begin
            state_r <= SHIFT;
            busy_r  <= 1'b1;
          end
        end
        SHIFT: begin
          if (load1_s) begin
            frm_err_r <= 1'b1;
          end else if (done_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Shift register: every accepted bit enters at the top, so bit 0 ends in sr_r[0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_r <= '0;
    end else if (strobe_s) begin
      sr_r <= word_s;
    end
  end

  // Output buffer; the handshake is honoured even while the block is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_r     <= '0;
      dout_vld_r <= 1'b0;
    end else if (done_s && (!dout_vld_r || hs_s)) begin
      dout_r     <= word_s;
      dout_vld_r <= 1'b1;
    end else if (hs_s) begin
      dout_vld_r <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (done_s && dout_vld_r && !hs_s) begin
      ovf_r <= 1'b1;
    end else if (bus.enb && bus.ovf_clr) begin
      ovf_r <= 1'b0;
    end
  end

  assign bus.dout     = dout_r;
  assign bus.dout_vld = dout_vld_r;
  assign bus.busy     = busy_r;
  assign bus.ovf      = ovf_r;
  assign bus.frm_err  = frm_err_r;

endmodule : sipo_lsb_rx

// File: tb/tb_sipo_lsb_rx.sv
// Directed bench for sipo_lsb_rx (DW=4) with hand-computed expectations.
module tb_sipo_lsb_rx;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  sipo_lsb_rx_if #(.DW(4)) bus ();

  sipo_lsb_rx #(
    .DW (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic s);
    bus.enb     = 1'b1;
    bus.sin_vld = 1'b1;
    bus.sin     = b;
    bus.sof     = s;
    tick();
    bus.sin_vld = 1'b0;
    bus.sof     = 1'b0;
    bus.sin     = 1'b0;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b0;
    bus.enb     = 1'b0;
    bus.sin     = 1'b0;
    bus.sin_vld = 1'b0;
    bus.sof     = 1'b0;
    bus.dout_rdy = 1'b0;
    bus.ovf_clr = 1'b0;
    tick();
    tick();
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_vld", 32'(bus.dout_vld), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_ovf", 32'(bus.ovf), 32'h0);
    chk("rst_frm", 32'(bus.frm_err), 32'h0);
    rst = 1'b1;
    tick();

    // Back-to-back 1,1,0,1 with consumer ready.
    bus.dout_rdy = 1'b1;
    send(1'b1, 1'b1);
    chk("s1_busy_on", 32'(bus.busy), 32'h1);
    chk("s1_vld_mid", 32'(bus.dout_vld), 32'h0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("s1_vld", 32'(bus.dout_vld), 32'h1);
    chk("s1_dout", 32'(bus.dout), 32'hB);
    chk("s1_busy_off", 32'(bus.busy), 32'h0);
    tick();
    chk("s1_vld_drop", 32'(bus.dout_vld), 32'h0);
    chk("s1_dout_keep", 32'(bus.dout), 32'hB);

    // Overflow: second word dropped while the first is unconsumed.
    bus.dout_rdy = 1'b0;
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("s2_vld1", 32'(bus.dout_vld), 32'h1);
    chk("s2_ovf0", 32'(bus.ovf), 32'h0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    chk("s2_dout_kept", 32'(bus.dout), 32'hB);
    chk("s2_ovf", 32'(bus.ovf), 32'h1);
    chk("s2_vld2", 32'(bus.dout_vld), 32'h1);
    bus.dout_rdy = 1'b1;
    bus.ovf_clr  = 1'b1;
    tick();
    bus.ovf_clr  = 1'b0;
    chk("s2_vld_clr", 32'(bus.dout_vld), 32'h0);
    chk("s2_ovf_clr", 32'(bus.ovf), 32'h0);

    // Completion coinciding with handshake of the previous word.
    bus.dout_rdy = 1'b0;
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    chk("s3_first", 32'(bus.dout), 32'h3);
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    bus.dout_rdy = 1'b1;
    send(1'b1, 1'b0);
    chk("s3_vld", 32'(bus.dout_vld), 32'h1);
    chk("s3_dout", 32'(bus.dout), 32'h9);
    chk("s3_ovf", 32'(bus.ovf), 32'h0);
    tick();
    chk("s3_vld_drop", 32'(bus.dout_vld), 32'h0);

    // Framing error: restart after two bits.
    send(1'b1, 1'b1);
    chk("s4_frm0", 32'(bus.frm_err), 32'h0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    chk("s4_frm_pulse", 32'(bus.frm_err), 32'h1);
    chk("s4_busy", 32'(bus.busy), 32'h1);
    send(1'b1, 1'b0);
    chk("s4_frm_end", 32'(bus.frm_err), 32'h0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    chk("s4_dout", 32'(bus.dout), 32'hE);
    chk("s4_vld", 32'(bus.dout_vld), 32'h1);
    chk("s4_frm_none", 32'(bus.frm_err), 32'h0);

    // Pause mid-word with strobes present while disabled.
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    bus.enb     = 1'b0;
    bus.sin_vld = 1'b1;
    bus.sin     = 1'b1;
    bus.sof     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s5_pause_vld", 32'(bus.dout_vld), 32'h0);
      chk("s5_pause_frm", 32'(bus.frm_err), 32'h0);
    end
    chk("s5_pause_busy", 32'(bus.busy), 32'h1);
    send(1'b1, 1'b0);
    chk("s5_not_done", 32'(bus.dout_vld), 32'h0);
    send(1'b1, 1'b0);
    chk("s5_vld", 32'(bus.dout_vld), 32'h1);
    chk("s5_dout", 32'(bus.dout), 32'hD);

    // Async reset mid-word while a word is pending.
    bus.dout_rdy = 1'b0;
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    chk("s6_pre_busy", 32'(bus.busy), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("s6_rst_dout", 32'(bus.dout), 32'h0);
    chk("s6_rst_vld", 32'(bus.dout_vld), 32'h0);
    chk("s6_rst_busy", 32'(bus.busy), 32'h0);
    chk("s6_rst_ovf", 32'(bus.ovf), 32'h0);
    chk("s6_rst_frm", 32'(bus.frm_err), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    send(1'b1, 1'b1);
    chk("s6_no_frm", 32'(bus.frm_err), 32'h0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    chk("s6_vld", 32'(bus.dout_vld), 32'h1);
    chk("s6_dout", 32'(bus.dout), 32'h5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sipo_lsb_rx

// File: doc/sipo_lsb_rx.md
# sipo_lsb_rx

Serial-to-parallel receiver that sits directly downstream of the LSB-first parallel-in/serial-out shift register. It reassembles `DW`-bit words from a framed, LSB-first bit stream (bit 0 first) and presents each word through a single-entry valid/ready output buffer. Overflow and framing errors are flagged rather than stalling the serial side.

## Interface
- `DW`, default 4: word width in bits; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `enb` in 1: block enable. When 0, inputs are ignored and all state holds, except the `dout` handshake, which still completes.
- `sin` in 1: serial data bit.
- `sin_vld` in 1: `sin` is a valid bit this cycle.
- `sof` in 1: qualifies `sin_vld`; marks bit 0 of a word.
- `dout` out DW: assembled word, with the first received bit in `dout[0]`.
- `dout_vld` out 1: `dout` holds an unconsumed word.
- `dout_rdy` in 1: consumer accepts `dout` when `dout_vld & dout_rdy`.
- `busy` out 1: a word is partially received (FSM in SHIFT).
- `ovf` out 1: sticky overflow flag.
- `ovf_clr` in 1: synchronous clear of `ovf`.
- `frm_err` out 1: one-cycle pulse on an aborted partial word.

## Operation
- A bit is accepted when `enb & sin_vld` in a cycle (the "bit strobe").
- Shift register `sr[DW-1:0]` shifts right on each accepted bit: `sr <= {sin, sr[DW-1:1]}`. After `DW` bits, the first bit sits in `sr[0]`.
- The bit counter `cnt` counts accepted bits, with width `$clog2(DW)`.
- FSM state IDLE:
  - Bit strobe with `sof=1`: the bit is bit 0. Set `cnt=1` and go to SHIFT.
  - Bit strobe with `sof=0`: ignored, no flag.
- FSM state SHIFT:
  - Bit strobe with `sof=0`: shift and increment `cnt`.
  - On the `DW`-th bit, complete the word and return to IDLE.
- Word completion: the next-cycle output buffer is loaded with `{sin, sr[DW-1:1]}`.
- Output buffer rules:
  - Empty, or handshake (`dout_vld & dout_rdy`) in the same cycle: load the word. `dout_vld` is 1 next cycle.
  - Full and no handshake: the new word is dropped, `dout`/`dout_vld` are unchanged, and `ovf` is set next cycle.
  - Handshake without completion: `dout_vld` clears next cycle. `dout` keeps its last value.
- Framing error: a bit strobe with `sof=1` while in SHIFT discards the partial word and pulses `frm_err` for one cycle. The strobed bit is taken as bit 0 of a new word (`cnt=1`, stay in SHIFT).
- `ovf_clr` and an overflow event in the same cycle: set wins.
- `DW=2` degenerates correctly: SHIFT lasts one bit.

## Timing
- Reset values: `dout=0`, `dout_vld=0`, `busy=0`, `ovf=0`, `frm_err=0`, FSM=IDLE, `cnt=0`, `sr=0`.
- Latency: `dout_vld` rises on the clock edge that samples the last bit, so it is visible in the cycle after the last strobe.
- Bits may be back-to-back (one per cycle) or have arbitrary gaps. Gaps never time out.
- Full throughput: with `dout_rdy` held at 1, one word is delivered every `DW` strobes with no loss.
- `busy` is 1 from the edge after the `sof` strobe until the edge that samples the last bit.
- `enb=0` mid-word pauses reception. Resuming continues at the same `cnt`.
- Async reset mid-word or mid-handshake clears everything immediately. A partial word is lost without `frm_err`.

## Structure
- Package `sipo_pkg` holds the state typedef `rx_state_e {IDLE, SHIFT}`.
- Sub-module `bit_cnt`: a parameterised up-counter with synchronous load-1 and enable, wrapping at `DW`. It also supplies the `last` indicator (`cnt==DW-1`).
- The top level holds the FSM, `sr`, the output buffer and the flags.

## Test plan
All scenarios use `DW=4`.
- Strobes 1,1,0,1 back-to-back, `sof` on the first, `dout_rdy=1` → `dout=4'b1011`, `dout_vld` high for exactly one cycle, one cycle after the 4th strobe.
- Two frames: 1011 with `dout_rdy=0`, then 0110 → `dout` stays `4'b1011` and `ovf=1`. Then `dout_rdy=1` with `ovf_clr` → `dout_vld=0`, `ovf=0`.
- Frame completes in the same cycle as a handshake of the previous word → the new word is loaded, `dout_vld` stays 1, `ovf=0`.
- `sof`+1, 0, then `sof`+0, 1, 1, 1 → `frm_err` pulses once, `dout=4'b1110`.
- Bits 1,0 of a frame, `enb=0` for 5 cycles with strobes present, then bits 1,1 → `dout=4'b1101`, with no extra bits absorbed.
- Assert `rst` after 2 bits, release, then send a full frame 0101 → all outputs are 0 during reset and `dout=4'b0101` afterwards.
